// File: rtl/pixel_scanner_if.sv
// Bus between the raster scanner, the per-pixel color sources and the palette/DAC stage.
// The master is the scanner; the slave side drives the strobe and source colors.
interface pixel_scanner_if #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COLOR_WIDTH = 4
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  // Strobe semantics: every clock with pixel_en high is exactly one pixel
  // transfer; there is no backpressure, and sources must return the color for
  // request_x/request_y one clock after the request registers change.
  logic                   pixel_en;
  logic [XW-1:0]          request_x;
  logic [YW-1:0]          request_y;
  logic [COLOR_WIDTH-1:0] cursor_color;
  logic [COLOR_WIDTH-1:0] canvas_color;
  logic [COLOR_WIDTH-1:0] vga_color;
  logic                   hsync_n;
  logic                   vsync_n;
  logic                   blank_n;
  logic                   frame_start;

  modport master (
    input  pixel_en, cursor_color, canvas_color,
    output request_x, request_y, vga_color, hsync_n, vsync_n, blank_n, frame_start
  );

  modport slave (
    output pixel_en, cursor_color, canvas_color,
    input  request_x, request_y, vga_color, hsync_n, vsync_n, blank_n, frame_start
  );
endinterface

// File: rtl/pixel_scanner.sv
// Walks the VGA raster, requests per-pixel colors from the layer sources and
// composites cursor over canvas with sync/blank aligned to the returned color.
module pixel_scanner #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int COLOR_WIDTH = 4,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  pixel_scanner_if.master   bus
);
  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef struct packed {
    logic valid;
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } pipe_t;

  logic [HW-1:0]          h_cnt_q, h_cnt_d;
  logic [VW-1:0]          v_cnt_q, v_cnt_d;
  logic [XW-1:0]          req_x_q, req_x_d;
  logic [YW-1:0]          req_y_q, req_y_d;
  pipe_t                  s0_q, s0_d;
  pipe_t                  s1_q;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic                   hsync_n_q, hsync_n_d;
  logic                   vsync_n_q, vsync_n_d;
  logic                   blank_n_q, blank_n_d;
  logic                   fs_q, fs_d;

  logic active, hs, vs, fs, h_last, v_last;

  // Comparisons are done at 32 bits so sync windows touching H_TOTAL/V_TOTAL cannot wrap.
  always_comb begin
    active = (32'(h_cnt_q) < WIDTH) && (32'(v_cnt_q) < HEIGHT);
    hs     = (32'(h_cnt_q) >= WIDTH + H_FRONT) && (32'(h_cnt_q) < WIDTH + H_FRONT + H_SYNC);
    vs     = (32'(v_cnt_q) >= HEIGHT + V_FRONT) && (32'(v_cnt_q) < HEIGHT + V_FRONT + V_SYNC);
    fs     = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_last = (32'(h_cnt_q) == H_TOTAL - 1);
    v_last = (32'(v_cnt_q) == V_TOTAL - 1);
  end

  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    req_x_d    = req_x_q;
    req_y_d    = req_y_q;
    s0_d       = s0_q;
    s0_d.valid = bus.pixel_en;
    if (bus.pixel_en) begin
      s0_d    = '{valid: 1'b1, active: active, hs: hs, vs: vs, fs: fs};
      req_x_d = active ? h_cnt_q[XW-1:0] : '0;
      req_y_d = active ? v_cnt_q[YW-1:0] : '0;
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  // Output stage loads only when a strobed pixel reaches it; everything but frame_start holds otherwise.
  always_comb begin
    color_d   = color_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    blank_n_d = blank_n_q;
    fs_d      = 1'b0;
    if (s1_q.valid) begin
      if (!s1_q.active)                     color_d = COLOR_NONE;
      else if (bus.cursor_color != COLOR_NONE) color_d = bus.cursor_color;
      else                                  color_d = bus.canvas_color;
      hsync_n_d = ~s1_q.hs;
      vsync_n_d = ~s1_q.vs;
      blank_n_d = s1_q.active;
      fs_d      = s1_q.fs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      req_x_q   <= '0;
      req_y_q   <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
      color_q   <= COLOR_NONE;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      req_x_q   <= req_x_d;
      req_y_q   <= req_y_d;
      s0_q      <= s0_d;
      s1_q      <= s0_q;
      color_q   <= color_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.request_x   = req_x_q;
  assign bus.request_y   = req_y_q;
  assign bus.vga_color   = color_q;
  assign bus.hsync_n     = hsync_n_q;
  assign bus.vsync_n     = vsync_n_q;
  assign bus.blank_n     = blank_n_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_pixel_scanner.sv
// Directed bench for pixel_scanner on an 8x4 visible raster (12x7 total) with a
// registered cursor/canvas source model and a reference raster scoreboard.
module tb_pixel_scanner;
  logic clk;
  logic reset_n;

  pixel_scanner_if #(.WIDTH(8), .HEIGHT(4), .COLOR_WIDTH(4)) bus ();

  pixel_scanner #(
    .WIDTH(8), .HEIGHT(4),
    .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .COLOR_WIDTH(4), .COLOR_NONE(4'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer sources: one clock of latency from the request registers.
  always @(posedge clk) begin
    bus.cursor_color <= (bus.request_x == 3'd3 && bus.request_y == 2'd2) ? 4'd5 : 4'd0;
    bus.canvas_color <= 4'd2;
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mx = 0, my = 0;
  int m5 = 0, n5 = 0;
  logic [7:0] exp_q[$];
  int         due_q[$];
  int         fs_cyc[$];
  logic [7:0] last_out;
  logic [2:0] exp_rx;
  logic [1:0] exp_ry;
  localparam logic [7:0] RESET_OUT = {4'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int x, input int y);
    logic act;
    logic [3:0] col;
    act = (x < 8) && (y < 4);
    col = !act ? 4'd0 : ((x == 3 && y == 2) ? 4'd5 : 4'd2);
    return {col, !(x >= 9 && x < 11), !(y == 5), act, (x == 0 && y == 0)};
  endfunction

  function automatic logic [7:0] obs_out();
    return {bus.vga_color, bus.hsync_n, bus.vsync_n, bus.blank_n, bus.frame_start};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    mx = 0; my = 0;
    last_out = RESET_OUT;
    exp_rx = '0; exp_ry = '0;
  endtask

  // One active clock edge, then check the outputs 1 time unit later.
  task automatic edge_step(input logic pen);
    logic [7:0] e;
    @(posedge clk);
    cyc++;
    if (pen) begin
      exp_q.push_back(exp_pix(mx, my));
      due_q.push_back(cyc + 2);
      if (mx == 3 && my == 2) m5++;
      exp_rx = (mx < 8 && my < 4) ? 3'(mx) : 3'd0;
      exp_ry = (mx < 8 && my < 4) ? 2'(my) : 2'd0;
      if (mx == 11) begin
        mx = 0;
        my = (my == 6) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    #1;
    chk("request_x", 32'(bus.request_x), 32'(exp_rx));
    chk("request_y", 32'(bus.request_y), 32'(exp_ry));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("pixel_out", 32'(obs_out()), 32'(e));
      if (bus.vga_color == 4'd5) n5++;
      last_out = {e[7:1], 1'b0};
    end else begin
      chk("hold_out", 32'(obs_out()), 32'(last_out));
    end
    if (bus.frame_start) fs_cyc.push_back(cyc);
  endtask

  task automatic tick(input logic pen);
    @(negedge clk);
    bus.pixel_en = pen;
    edge_step(pen);
  endtask

  initial begin
    int rel_cyc;
    int npix;
    reset_n = 1'b0;
    bus.pixel_en = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(obs_out()), 32'(RESET_OUT));
    chk("reset_req", {30'd0, bus.request_x == 3'd0, bus.request_y == 2'd0}, 32'd3);

    // Strobe held low after release: nothing but reset values may appear.
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) tick(1'b0);

    // Constant strobe, two frames plus drain.
    fs_cyc.delete();
    repeat (2 * 84 + 3) tick(1'b1);
    chk("fs_period_fast", (fs_cyc.size() >= 2) ? 32'(fs_cyc[1] - fs_cyc[0]) : 32'hffff, 32'd84);

    // Strobe every second clock.
    fs_cyc.delete();
    repeat (2 * 84 + 2) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("fs_period_slow", (fs_cyc.size() >= 2) ? 32'(fs_cyc[1] - fs_cyc[0]) : 32'hffff, 32'd168);

    // Random gaps of 1-4 clocks between strobes.
    npix = 0;
    while (npix < 100) begin
      tick(1'b1);
      npix++;
      repeat ($urandom_range(0, 3)) tick(1'b0);
    end

    // Reset mid-frame with pixels in flight.
    tick(1'b1);
    tick(1'b1);
    reset_n = 1'b0;
    #1;
    chk("midreset_out", 32'(obs_out()), 32'(RESET_OUT));
    chk("midreset_req", {30'd0, bus.request_x == 3'd0, bus.request_y == 2'd0}, 32'd3);
    model_reset();
    bus.pixel_en = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.pixel_en = 1'b1;
    rel_cyc = cyc;
    fs_cyc.delete();
    edge_step(1'b1);
    repeat (40) tick(1'b1);
    chk("fs_after_release", (fs_cyc.size() >= 1) ? 32'(fs_cyc[0] - rel_cyc) : 32'hffff, 32'd3);

    repeat (4) tick(1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("cursor_hits", 32'(n5), 32'(m5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_scanner.md
# pixel_scanner

Read-side counterpart to the per-pixel color sources (cursor layer, canvas layer). It walks the visible raster in VGA order and drives `request_x`/`request_y` to those sources. It takes back their colors, which arrive one clock after the request, and composites the cursor over the canvas. It then emits a color index plus sync/blank signals aligned to that color, ready for the palette/DAC stage.

## Interface
Parameters:
- `WIDTH`, 640: visible pixels per line.
- `HEIGHT`, 480: visible lines per frame.
- `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal porch and sync widths, in pixels.
- `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical porch and sync widths, in lines.
- Derived values:
  - `H_TOTAL` = `WIDTH+H_FRONT+H_SYNC+H_BACK`
  - `V_TOTAL` = `HEIGHT+V_FRONT+V_SYNC+V_BACK`
  - `COLOR_WIDTH` and `COLOR_NONE` come from `common.sv`.

Ports:
- `clk`, input, 1: system clock. One clock; reset is asynchronous and active-low.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `pixel_en`, input, 1: pixel-rate strobe. Each high cycle advances the raster by one pixel.
- `request_x`, output, `$clog2(WIDTH)`: column requested from the sources.
- `request_y`, output, `$clog2(HEIGHT)`: row requested from the sources.
- `cursor_color`, input, `COLOR_WIDTH`: cursor layer color. Valid 1 clk after the request changes.
- `canvas_color`, input, `COLOR_WIDTH`: canvas layer color, same latency as `cursor_color`.
- `vga_color`, output, `COLOR_WIDTH`: composited pixel.
- `hsync_n`, output, 1: horizontal sync, active low.
- `vsync_n`, output, 1: vertical sync, active low.
- `blank_n`, output, 1: high during the visible region.
- `frame_start`, output, 1: one-clk pulse marking pixel (0,0) on the outputs.

## Operation
- **Raster counters:**
  - `h_cnt` runs 0..`H_TOTAL-1`; `v_cnt` runs 0..`V_TOTAL-1`.
  - Both advance only on clocks with `pixel_en`=1.
  - `h_cnt` wraps to 0 at `H_TOTAL-1` and increments `v_cnt` on that wrap.
  - `v_cnt` wraps to 0 at `V_TOTAL-1` on the same wrap edge.
- **Request stage (stage 0):** registered on each `pixel_en` edge, from the counter value being presented.
  - `active` = `h_cnt<WIDTH && v_cnt<HEIGHT`.
  - `request_x` = `h_cnt` and `request_y` = `v_cnt` when active; both hold 0 when not active. No out-of-range address ever leaves the block.
  - `hs` = `h_cnt` in [`WIDTH+H_FRONT`, `WIDTH+H_FRONT+H_SYNC`).
  - `vs` = `v_cnt` in [`HEIGHT+V_FRONT`, `HEIGHT+V_FRONT+V_SYNC`).
  - `fs` = (`h_cnt`==0 && `v_cnt`==0).
- **Alignment pipe:** a 2-deep shift register carrying {valid, `active`, `hs`, `vs`, `fs`}.
  - It advances every clk, independent of `pixel_en`.
  - Valid is set by `pixel_en` at stage 0.
- **Output stage (stage 2):** loads only when the pipe's valid bit reaches it, i.e. exactly 2 clk after the stage-0 load.
  - `vga_color` = `COLOR_NONE` if not active.
  - Otherwise `vga_color` = `cursor_color` if `cursor_color != COLOR_NONE`, else `canvas_color`.
  - `hsync_n` = ~`hs`, `vsync_n` = ~`vs`, `blank_n` = `active`.
  - `frame_start` = `fs`, forced to 0 on any clk where the output stage does not load.
- **Hold behaviour:** outputs other than `frame_start` hold between loads.
- **`pixel_en` rate:** any rate is legal, including constant 1. Per-pixel latency is fixed in clks, so mixed rates cannot misalign color and syncs.

## Timing
- **Reset values (`reset_n` low, immediate):**
  - `h_cnt`, `v_cnt`, `request_x`, `request_y` = 0.
  - Pipe valid bits = 0.
  - `vga_color` = `COLOR_NONE`.
  - `hsync_n` = 1, `vsync_n` = 1, `blank_n` = 0, `frame_start` = 0.
- **Reset release:** the first `pixel_en` edge registers pixel (0,0). Its outputs, with `frame_start`=1, appear 2 clk later.
- **Reset mid-frame:** all in-flight pipe entries are discarded, and no output load occurs until a new `pixel_en` has propagated. The raster restarts at (0,0).
- **Latency:** request → `vga_color`/syncs is 2 clk. Source data is sampled exactly 1 clk after the request register changes.
- **Boundary cases:**
  - At `h_cnt`=`H_TOTAL-1`, `v_cnt`=`V_TOTAL-1`, the next `pixel_en` produces (0,0) and `fs`.
  - Wraps are computed at full counter width with no truncation. `$clog2(H_TOTAL)`/`$clog2(V_TOTAL)` bits are used internally.
- **`pixel_en` after reset:** `pixel_en` low at reset release or for long stretches must not alter outputs beyond `frame_start` returning to 0.

## Test plan
All scenarios use `WIDTH`=8, `HEIGHT`=4, all porches/syncs = 1, 2, 1 horizontal and 1, 1, 1 vertical. This gives `H_TOTAL`=12, `V_TOTAL`=7 and 84 pixels per frame.
- **Reset:** `reset_n`=0 mid-frame → all outputs at reset values in the same cycle. After release with `pixel_en`=1: `frame_start`=1 exactly 3 clk after the release edge, `blank_n`=1, and the output color matches `canvas_color` for (0,0).
- **Compositing:** model sources returning `canvas_color`=2 everywhere and `cursor_color`=5 only at (3,2), `COLOR_NONE` elsewhere, each with 1-clk latency. Required: `vga_color`=5 only on the (3,2) output load, 2 elsewhere in the visible region, and `COLOR_NONE` with `blank_n`=0 in blanking.
- **Sync geometry (`pixel_en`=1 constant):**
  - `hsync_n` low for exactly 2 pixels per line, starting 9 pixels after line start.
  - `vsync_n` low for exactly 1 line (12 clk), starting at line 5.
  - `frame_start` period = 84 clk.
- **Slow strobe:** `pixel_en` high every 2nd clk → identical output sequence to the previous case, with each value held 2 clk and `frame_start` period 168 clk. Then randomize `pixel_en` gaps (1-4 clk) → color/sync alignment is unchanged.
- **Address range:** across 3 frames, `request_x` ≤ 7 and `request_y` ≤ 3 always. Both are 0 on every blanking request.
